// File: rtl/vram_fifo_port_if.sv
// VRAM port bundle: controller-side FIFO access plus the req/ack memory bus.
// slave = the memory-side responder, master = controller and memory model.
interface vram_fifo_port_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              write_ld;
    logic [ADDR_W-1:0] writeaddr;
    logic              write_req;
    logic [DATA_W-1:0] writedata;
    logic              read_ld;
    logic [ADDR_W-1:0] readaddr;
    logic              read_req;
    logic [DATA_W-1:0] readdata;
    logic [15:0]       wr_buffer;
    logic [15:0]       rd_buffer;
    logic              wr_overflow;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  write_ld, writeaddr, write_req, writedata,
        input  read_ld, readaddr, read_req,
        output readdata, wr_buffer, rd_buffer, wr_overflow,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output write_ld, writeaddr, write_req, writedata,
        output read_ld, readaddr, read_req,
        input  readdata, wr_buffer, rd_buffer, wr_overflow,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/vram_fifo_port.sv
// VRAM memory-side responder: write FIFO drain, read burst prefetch,
// and a round-robin arbiter over a single req/ack memory port.
module vram_fifo_port #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int WR_DEPTH = 16,
    parameter int RD_DEPTH = 16,
    parameter int RD_BURST = 10
) (
    input logic             clk,
    input logic             reset,
    vram_fifo_port_if.slave bus
);
    localparam int WA = $clog2(WR_DEPTH);
    localparam int RA = $clog2(RD_DEPTH);
    localparam int BW = $clog2(RD_BURST + 1);

    localparam logic [WA:0]   W_FULL = (WA + 1)'(WR_DEPTH);
    localparam logic [RA:0]   R_FULL = (RA + 1)'(RD_DEPTH);
    localparam logic [BW-1:0] BURST  = BW'(RD_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // write side
    logic [DATA_W-1:0] wr_mem [WR_DEPTH];
    logic [WA-1:0]     wr_head;
    logic [WA-1:0]     wr_tail;
    logic [WA:0]       wr_count;
    logic [WA:0]       wr_level;
    logic              wr_out;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_ovf_q;
    logic              wr_try;
    logic              wr_push;
    logic              wr_drop;
    logic              wr_pend;

    // read side
    logic [DATA_W-1:0] rd_mem [RD_DEPTH];
    logic [RA-1:0]     rd_head;
    logic [RA-1:0]     rd_tail;
    logic [RA:0]       rd_count;
    logic [RA:0]       rd_fill;
    logic [ADDR_W-1:0] rd_addr;
    logic [BW-1:0]     rd_remain;
    logic              epoch;
    logic              rd_tag;
    logic              rd_push;
    logic              rd_pop;
    logic              rd_pend;

    // arbiter / memory port
    logic              last_rd;
    logic              issue_wr;
    logic              issue_rd;
    logic              wr_done;
    logic              rd_done;
    logic              mem_req_c;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // The in-flight write counts against capacity so wr_buffer never exceeds WR_DEPTH.
    assign wr_level = wr_count + (WA + 1)'(wr_out);
    assign wr_try   = bus.write_req && !bus.write_ld;
    assign wr_push  = wr_try && (wr_level < W_FULL);
    assign wr_drop  = wr_try && !(wr_level < W_FULL);
    assign wr_pend  = (wr_count != '0) && !bus.write_ld;

    // A prefetch may only issue if its return is guaranteed a FIFO slot.
    assign rd_fill  = rd_count + (RA + 1)'(state_q == RD_BUSY);
    assign rd_pend  = (rd_remain != '0) && (rd_fill < R_FULL) && !bus.read_ld;
    assign rd_push  = rd_done && (rd_tag == epoch) && !bus.read_ld;
    assign rd_pop   = bus.read_req && (rd_count != '0) && !bus.read_ld;

    // Arbiter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbiter next state: round-robin when both sides want the port.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wr_pend && (!rd_pend || last_rd)) begin
                    state_d = WR_BUSY;
                end else if (rd_pend) begin
                    state_d = RD_BUSY;
                end
            end
            WR_BUSY, RD_BUSY: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter outputs: issue strobes, completion strobes and mem_req.
    always_comb begin
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        wr_done   = 1'b0;
        rd_done   = 1'b0;
        mem_req_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                issue_wr = (state_d == WR_BUSY);
                issue_rd = (state_d == RD_BUSY);
            end
            WR_BUSY: begin
                mem_req_c = 1'b1;
                wr_done   = bus.mem_ack;
            end
            RD_BUSY: begin
                mem_req_c = 1'b1;
                rd_done   = bus.mem_ack;
            end
            default: ;
        endcase
    end

    // Memory command registers, captured at issue and held until ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            last_rd     <= 1'b1;
        end else begin
            if (issue_wr) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= wr_addr;
                mem_wdata_q <= wr_mem[wr_head];
            end else if (issue_rd) begin
                mem_we_q    <= 1'b0;
                mem_addr_q  <= rd_addr;
                mem_wdata_q <= '0;
            end
            if (wr_done) begin
                last_rd <= 1'b0;
            end else if (rd_done) begin
                last_rd <= 1'b1;
            end
        end
    end

    // Write FIFO control; a load flushes but leaves an in-flight write alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_head  <= '0;
            wr_tail  <= '0;
            wr_count <= '0;
            wr_addr  <= '0;
            wr_out   <= 1'b0;
            wr_ovf_q <= 1'b0;
        end else begin
            if (wr_drop) begin
                wr_ovf_q <= 1'b1;
            end
            if (issue_wr) begin
                wr_out <= 1'b1;
            end else if (wr_done) begin
                wr_out <= 1'b0;
            end
            if (bus.write_ld) begin
                wr_head  <= '0;
                wr_tail  <= '0;
                wr_count <= '0;
                wr_addr  <= bus.writeaddr;
            end else begin
                if (wr_push) begin
                    wr_tail <= wr_tail + WA'(1);
                end
                if (issue_wr) begin
                    wr_head <= wr_head + WA'(1);
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
                wr_count <= wr_count + (WA + 1)'(wr_push)
                            - (WA + 1)'(issue_wr);
            end
        end
    end

    // Write FIFO storage.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            wr_mem[wr_tail] <= bus.writedata;
        end
    end

    // Read FIFO control; the epoch bit marks returns that predate a reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_head   <= '0;
            rd_tail   <= '0;
            rd_count  <= '0;
            rd_addr   <= '0;
            rd_remain <= '0;
            epoch     <= 1'b0;
            rd_tag    <= 1'b0;
        end else begin
            if (bus.read_ld) begin
                rd_head   <= '0;
                rd_tail   <= '0;
                rd_count  <= '0;
                rd_addr   <= bus.readaddr;
                rd_remain <= BURST;
                epoch     <= ~epoch;
            end else begin
                if (rd_push) begin
                    rd_tail <= rd_tail + RA'(1);
                end
                if (rd_pop) begin
                    rd_head <= rd_head + RA'(1);
                end
                if (issue_rd) begin
                    rd_addr   <= rd_addr + ADDR_W'(1);
                    rd_remain <= rd_remain - BW'(1);
                    rd_tag    <= epoch;
                end
                rd_count <= rd_count + (RA + 1)'(rd_push)
                            - (RA + 1)'(rd_pop);
            end
        end
    end

    // Read FIFO storage.
    always_ff @(posedge clk) begin
        if (rd_push) begin
            rd_mem[rd_tail] <= bus.mem_rdata;
        end
    end

    assign bus.readdata    = (rd_count != '0) ? rd_mem[rd_head] : '0;
    assign bus.wr_buffer   = 16'(wr_level);
    assign bus.rd_buffer   = 16'(rd_count);
    assign bus.wr_overflow = wr_ovf_q;
    assign bus.mem_req     = mem_req_c;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_vram_fifo_port.sv
// Bench for vram_fifo_port: memory model with programmable ack delay,
// scoreboard queues for writes and read data, grant-order log.
module tb_vram_fifo_port;
    logic clk;
    logic reset;

    vram_fifo_port_if #(.ADDR_W(25), .DATA_W(16)) bus ();

    vram_fifo_port #(
        .ADDR_W(25), .DATA_W(16), .WR_DEPTH(16),
        .RD_DEPTH(16), .RD_BURST(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [24:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    bit          grant_log[$];
    int          rd_issues;
    int          rd_base;
    int          checks;
    int          errors;
    int          ack_delay;
    bit          hold;
    logic [24:0] wr_ptr;
    bit          prev_req;

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // memory model: acks ack_delay cycles after seeing mem_req, returns addr+1
    initial begin
        int  cnt;
        bit  busy;
        busy = 1'b0;
        cnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else if (!hold) begin
                if (!busy && bus.mem_req) begin
                    busy = 1'b1;
                    cnt = ack_delay;
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = 16'(bus.mem_addr + 25'd1);
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    // monitor: logs grants, checks completed writes and popped read words
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (bus.mem_req && !prev_req) begin
                grant_log.push_back(bus.mem_we);
                if (!bus.mem_we) rd_issues++;
            end
            prev_req = bus.mem_req;
            if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", bus.mem_addr, e.a);
                    check("wr_data", bus.mem_wdata, e.d);
                end
            end
            if (bus.read_req && bus.rd_buffer != 0) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    check("rd_data", bus.readdata, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_load(input logic [24:0] a);
        bus.write_ld = 1'b1;
        bus.writeaddr = a;
        wr_ptr = a;
        tick();
        bus.write_ld = 1'b0;
    endtask

    task automatic rd_fill_model(input logic [24:0] a);
        exp_rd.delete();
        for (int i = 0; i < 10; i++) begin
            logic [24:0] wa;
            wa = a + 25'(i);
            exp_rd.push_back(16'(wa + 25'd1));
        end
        rd_base = rd_issues;
    endtask

    task automatic rd_load(input logic [24:0] a);
        bus.read_req = 1'b0;
        bus.read_ld = 1'b1;
        bus.readaddr = a;
        rd_fill_model(a);
        tick();
        bus.read_ld = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d, input bit acc);
        bus.write_req = 1'b1;
        bus.writedata = d;
        if (acc) begin
            exp_wr.push_back({wr_ptr, d});
            wr_ptr = wr_ptr + 25'd1;
        end
        tick();
        bus.write_req = 1'b0;
    endtask

    task automatic wait_wr_empty(input int maxc, input string nm);
        int k;
        k = 0;
        while (bus.wr_buffer != 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(nm, bus.wr_buffer, 0);
    endtask

    task automatic wait_rd_level(input int lvl, input int maxc,
                                 input string nm);
        int k;
        k = 0;
        while (bus.rd_buffer != 16'(lvl) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(nm, bus.rd_buffer, lvl);
    endtask

    task automatic wait_req(input int maxc, input string nm);
        int k;
        k = 0;
        while (!bus.mem_req && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(nm, bus.mem_req, 1);
    endtask

    task automatic drain_reads(input int maxc, input string nm);
        int k;
        k = 0;
        bus.read_req = 1'b1;
        while ((exp_rd.size() != 0 || bus.wr_buffer != 0) && k < maxc) begin
            tick();
            k++;
        end
        tick();
        bus.read_req = 1'b0;
        check({nm, "_left"}, exp_rd.size(), 0);
        check({nm, "_rdbuf"}, bus.rd_buffer, 0);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_req"}, bus.mem_req, 0);
        check({nm, "_we"}, bus.mem_we, 0);
        check({nm, "_addr"}, bus.mem_addr, 0);
        check({nm, "_wdata"}, bus.mem_wdata, 0);
        check({nm, "_rdata"}, bus.readdata, 0);
        check({nm, "_wrbuf"}, bus.wr_buffer, 0);
        check({nm, "_rdbuf"}, bus.rd_buffer, 0);
        check({nm, "_ovf"}, bus.wr_overflow, 0);
    endtask

    initial begin
        int lvl;
        int w;
        int r;
        int gbase;
        bit last_rd;
        bit exp_g[$];
        checks = 0;
        errors = 0;
        rd_issues = 0;
        rd_base = 0;
        hold = 1'b0;
        ack_delay = 3;
        wr_ptr = '0;
        reset = 1'b1;
        bus.write_ld = 1'b0;
        bus.writeaddr = '0;
        bus.write_req = 1'b0;
        bus.writedata = '0;
        bus.read_ld = 1'b0;
        bus.readaddr = '0;
        bus.read_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // single write, ack 3 cycles after mem_req
        ack_delay = 3;
        wr_load(25'h2A);
        push_word(16'h0F00, 1'b1);
        @(negedge clk);
        check("w1_buf_after_push", bus.wr_buffer, 1);
        check("w1_req_early", bus.mem_req, 0);
        @(negedge clk);
        check("w1_req_lat2", bus.mem_req, 1);
        check("w1_we", bus.mem_we, 1);
        check("w1_addr", bus.mem_addr, 25'h2A);
        check("w1_wdata", bus.mem_wdata, 16'h0F00);
        check("w1_buf_out", bus.wr_buffer, 1);
        begin
            int k;
            k = 0;
            while (!bus.mem_ack && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("w1_ack_seen", bus.mem_ack, 1);
            check("w1_buf_at_ack", bus.wr_buffer, 1);
            @(negedge clk);
            check("w1_buf_after_ack", bus.wr_buffer, 0);
        end
        tick();

        // overflow: ack held off, 17 consecutive pushes
        hold = 1'b1;
        wr_load(25'h0);
        lvl = 0;
        for (int i = 0; i < 17; i++) begin
            bit acc;
            acc = (lvl < 16);
            if (acc) lvl++;
            push_word(16'(16'hA000 + i), acc);
        end
        @(negedge clk);
        check("ovf_wrbuf", bus.wr_buffer, 16);
        check("ovf_flag", bus.wr_overflow, 1);
        tick();
        hold = 1'b0;
        wait_wr_empty(300, "ovf_drain");
        check("ovf_all_written", exp_wr.size(), 0);
        check("ovf_sticky", bus.wr_overflow, 1);
        tick();

        // read burst 0x50, latency and ordering
        ack_delay = 2;
        rd_load(25'h50);
        @(negedge clk);
        check("r1_req_early", bus.mem_req, 0);
        @(negedge clk);
        check("r1_req_lat2", bus.mem_req, 1);
        check("r1_we", bus.mem_we, 0);
        check("r1_addr", bus.mem_addr, 25'h50);
        wait_rd_level(10, 200, "r1_fill");
        repeat (10) @(negedge clk);
        check("r1_hold_level", bus.rd_buffer, 10);
        check("r1_issues", rd_issues - rd_base, 10);
        check("r1_head", bus.readdata, 16'h51);
        tick();
        drain_reads(40, "r1");
        @(negedge clk);
        check("r1_empty_rdata", bus.readdata, 0);
        check("r1_no_11th", rd_issues - rd_base, 10);
        tick();

        // stale return discarded after reload
        ack_delay = 4;
        rd_load(25'h50);
        wait_req(20, "st_first_req");
        tick();
        rd_load(25'h64);
        wait_rd_level(10, 300, "st_fill");
        check("st_head", bus.readdata, 16'h65);
        check("st_issues", rd_issues - rd_base, 10);
        tick();
        drain_reads(40, "st");

        // arbitration: writes and read burst pending together
        ack_delay = 2;
        wr_load(25'h100);
        gbase = grant_log.size();
        bus.read_ld = 1'b1;
        bus.readaddr = 25'h200;
        rd_fill_model(25'h200);
        push_word(16'hB000, 1'b1);
        bus.read_ld = 1'b0;
        push_word(16'hB001, 1'b1);
        push_word(16'hB002, 1'b1);
        wait_rd_level(10, 400, "arb_fill");
        wait_wr_empty(100, "arb_wr_drain");
        w = 3;
        r = 10;
        last_rd = 1'b1;
        while (w > 0 || r > 0) begin
            if (w > 0 && (r == 0 || last_rd)) begin
                exp_g.push_back(1'b1);
                w--;
                last_rd = 1'b0;
            end else begin
                exp_g.push_back(1'b0);
                r--;
                last_rd = 1'b1;
            end
        end
        check("arb_count", grant_log.size() - gbase, exp_g.size());
        for (int i = 0; i < exp_g.size() && gbase + i < grant_log.size(); i++)
            check($sformatf("arb_grant%0d", i), grant_log[gbase + i], exp_g[i]);
        tick();
        drain_reads(40, "arb");

        // randomized mixed traffic
        for (int it = 0; it < 5; it++) begin
            int n;
            int np;
            logic [24:0] aw;
            logic [24:0] ar;
            ack_delay = $urandom_range(1, 4);
            aw = (it == 0) ? 25'h1FFFFFA : 25'($urandom);
            ar = (it == 1) ? 25'h1FFFFFC : 25'($urandom);
            n = $urandom_range(1, 14);
            np = 0;
            wr_load(aw);
            rd_load(ar);
            for (int c = 0; c < 40; c++) begin
                bus.write_req = (np < n) && ($urandom_range(0, 1) == 1);
                if (bus.write_req) begin
                    logic [15:0] d;
                    d = 16'($urandom);
                    bus.writedata = d;
                    exp_wr.push_back({wr_ptr, d});
                    wr_ptr = wr_ptr + 25'd1;
                    np++;
                end
                bus.read_req = ($urandom_range(0, 1) == 1);
                tick();
            end
            bus.write_req = 1'b0;
            drain_reads(400, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_wr_left", it), exp_wr.size(), 0);
            check($sformatf("rnd%0d_wrbuf", it), bus.wr_buffer, 0);
            check($sformatf("rnd%0d_issues", it), rd_issues - rd_base, 10);
        end

        // reset in the middle of a burst
        ack_delay = 5;
        rd_load(25'h300);
        wait_req(20, "rst_req_seen");
        #3;
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        exp_rd.delete();
        exp_wr.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        gbase = grant_log.size();
        repeat (12) tick();
        @(negedge clk);
        check("rst_no_req", bus.mem_req, 0);
        check("rst_no_grants", grant_log.size() - gbase, 0);
        check("rst_rdbuf", bus.rd_buffer, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vram_fifo_port.md
Name: vram_fifo_port

Overview:
Memory-side responder for the VRAM write/read port driven by the game controller. It accepts address loads and write pushes into a write FIFO, then drains them into backing memory. On each read address load it prefetches a fixed burst into a read FIFO. It reports FIFO occupancy on wr_buffer and rd_buffer, and arbitrates a single req/ack memory interface between write drains and read prefetches.

Parameters:
ADDR_W, 25, VRAM word address width
DATA_W, 16, pixel/cell word width
WR_DEPTH, 16, write FIFO entries (power of 2)
RD_DEPTH, 16, read FIFO entries (power of 2, >= RD_BURST)
RD_BURST, 10, words prefetched per read_ld (one playfield row)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
write_ld  in  1  flush write FIFO, load writeaddr as write pointer
writeaddr  in  ADDR_W  start address for subsequent writes
write_req  in  1  push writedata this cycle
writedata  in  DATA_W  write word
read_ld  in  1  flush read FIFO, load readaddr, start burst
readaddr  in  ADDR_W  burst start address
read_req  in  1  pop read FIFO head this cycle
readdata  out  DATA_W  read FIFO head (show-ahead), 0 when empty
wr_buffer  out  16  write FIFO words + outstanding memory write (0 = all committed)
rd_buffer  out  16  read FIFO words available
wr_overflow  out  1  sticky: push attempted while full
mem_req  out  1  memory transaction request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack when mem_we=0

Behaviour:
- Reset (async): FIFOs empty, pointers/addresses 0, burst remaining 0, state IDLE, mem_req/mem_we/wr_overflow 0, mem_addr/mem_wdata 0, readdata 0, wr_buffer/rd_buffer 0, last_grant = read.
- Write side:
  - write_ld: write FIFO count <= 0; wr_addr <= writeaddr. Does not cancel an in-flight memory write.
  - write_req & !write_ld: push writedata if count < WR_DEPTH, else drop and set wr_overflow.
  - write_req & write_ld in the same cycle: load wins, push ignored.
  - Each drained entry goes to wr_addr. wr_addr increments (mod 2^ADDR_W) at issue.
  - wr_buffer = FIFO count + (1 if write outstanding). It reaches 0 on the cycle after the final mem_ack.
- Read side:
  - read_ld: read FIFO count <= 0; rd_addr <= readaddr; remaining <= RD_BURST; epoch bit toggles.
  - Prefetch issues when remaining > 0 and (count + outstanding) < RD_DEPTH. rd_addr increments and remaining decrements at issue.
  - mem_ack data is pushed only if its tag epoch equals the current epoch; stale returns after read_ld are discarded.
  - After RD_BURST words, no further reads occur until the next read_ld.
  - read_req: pop head if count > 0, ignored if empty. Push and pop in the same cycle leave count unchanged.
  - readdata is combinational from the head entry.
- Arbiter FSM: IDLE, WR_BUSY, RD_BUSY.
  - IDLE, only write pending (write FIFO nonempty): issue write, go WR_BUSY.
  - IDLE, only read pending: issue read, go RD_BUSY.
  - IDLE, both pending: grant the opposite of last_grant (round-robin).
  - Issue: mem_req=1, with mem_we/mem_addr/mem_wdata registered in the same cycle.
  - WR_BUSY/RD_BUSY: hold all memory outputs until mem_ack. On mem_ack: mem_req <= 0, go IDLE, update last_grant.
  - At least one IDLE cycle between transactions; only one transaction outstanding at a time.
  - mem_ack in IDLE is ignored.
- Latency:
  - write_req to mem_req: 2 cycles when idle.
  - read_ld to first mem_req: 2 cycles.
  - mem_ack to rd_buffer increment: 1 cycle.
- Reset mid-transaction abandons it; the memory is reset by the same signal.

Test Plan:
- Reset asserted mid-burst -> all outputs 0 within the same cycle, state IDLE, no mem_req.
- write_ld addr 0x2A, then one write_req data 0x0F00, mem_ack 3 cycles after mem_req -> mem_addr 0x2A, mem_wdata 0x0F00, mem_we 1; wr_buffer 1 then 0 after ack.
- mem_ack held off; write_ld addr 0, then 17 consecutive write_req -> wr_buffer 16 (15 FIFO + 1 outstanding after first issue), wr_overflow 1; after release, exactly 16 writes to addresses 0..15.
- Memory returns addr+1; read_ld addr 0x50 -> rd_buffer reaches 10. Then hold read_req -> readdata 0x51..0x5A in order, rd_buffer 0, no 11th read.
- read_ld 0x50, then read_ld 0x64 while the first read is outstanding -> stale word discarded; FIFO holds 0x65..0x6E only.
- Write FIFO nonempty and read burst pending together -> grants alternate W,R,W,R, starting opposite to last_grant.
